// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer:
// FSM states, reset-cause codes and the per-state domain release mask.
package reset_seq_pkg;

  localparam int CNT_W       = 16;
  localparam int NUM_DOMAINS = 3;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    REL0 = 2'd1,
    REL1 = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;
  localparam logic [1:0] CAUSE_SW  = 2'b11;

  // Active-low domain resets per state; lower domains always release first.
  function automatic logic [NUM_DOMAINS-1:0] stage_mask(input state_t s);
    case (s)
      HOLD:    stage_mask = 3'b000;
      REL0:    stage_mask = 3'b001;
      REL1:    stage_mask = 3'b011;
      RUN:     stage_mask = 3'b111;
      default: stage_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: holds all domain resets after the last cause,
// then releases memory/clock, CPU and peripheral domains in order.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ext_rst_req,
  input  logic       wdt_expire,
  input  logic       sw_rst_req,
  output logic [2:0] rst_out_n,
  output logic       busy,
  output logic [1:0] rst_cause
);
  import reset_seq_pkg::*;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [NUM_DOMAINS-1:0] out_reg, out_next;
  logic                   busy_reg, busy_next;
  logic [1:0]             cause_reg, cause_next;
  logic                   req;

  assign req = ext_rst_req | wdt_expire | sw_rst_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= HOLD;
      cnt_reg   <= '0;
      out_reg   <= '0;
      busy_reg  <= 1'b1;
      cause_reg <= CAUSE_POR;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      busy_reg  <= busy_next;
      cause_reg <= cause_next;
    end
  end

  // Counter terminates at the last value of each phase, so it never wraps.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cause_next = cause_reg;
    if (req) begin
      state_next = HOLD;
      cnt_next   = '0;
      if (ext_rst_req)     cause_next = CAUSE_EXT;
      else if (wdt_expire) cause_next = CAUSE_WDT;
      else                 cause_next = CAUSE_SW;
    end else begin
      case (state_reg)
        HOLD: begin
          if (cnt_reg == HOLD_LAST) begin
            state_next = REL0;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        REL0: begin
          if (cnt_reg == GAP_LAST) begin
            state_next = REL1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        REL1: begin
          if (cnt_reg == GAP_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        RUN: cnt_next = '0;
        default: begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      endcase
    end
    // Outputs are decoded from the next state so they register cleanly.
    out_next  = stage_mask(state_next);
    busy_next = (state_next != RUN);
  end

  assign rst_out_n = out_reg;
  assign busy      = busy_reg;
  assign rst_cause = cause_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: time-since-cause reference model feeding a
// scoreboard, directed timing sequences, and a segment table plus random run.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int H_A = 16;
  localparam int G_A = 4;
  localparam int H_B = 1;
  localparam int G_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic ext = 1'b0;
  logic wdt = 1'b0;
  logic sw  = 1'b0;

  logic [2:0] out_a, out_b;
  logic       busy_a, busy_b;
  logic [1:0] cause_a, cause_b;

  reset_sequencer #(.HOLD_CYCLES(H_A), .STAGE_GAP(G_A)) dut_a (
    .clk(clk), .rst(rst), .ext_rst_req(ext), .wdt_expire(wdt), .sw_rst_req(sw),
    .rst_out_n(out_a), .busy(busy_a), .rst_cause(cause_a)
  );

  reset_sequencer #(.HOLD_CYCLES(H_B), .STAGE_GAP(G_B)) dut_b (
    .clk(clk), .rst(rst), .ext_rst_req(ext), .wdt_expire(wdt), .sw_rst_req(sw),
    .rst_out_n(out_b), .busy(busy_b), .rst_cause(cause_b)
  );

  typedef struct {
    logic [2:0] out_a;
    logic       busy_a;
    logic [2:0] out_b;
    logic       busy_b;
    logic [1:0] cause;
  } exp_t;

  typedef struct {
    logic  r;
    logic  e;
    logic  w;
    logic  s;
    int    cycles;
    string name;
  } seg_t;

  int         vectors     = 0;
  int         miscompares = 0;
  int         m_since     = 0;
  logic [1:0] m_cause     = CAUSE_POR;
  exp_t       sb[$];
  seg_t       segs[8];

  // Expected mask from clocks elapsed since the edge that sampled the last cause.
  function automatic logic [2:0] exp_out(input int s, input int h, input int g);
    if (s < h)              return 3'b000;
    else if (s < h + g)     return 3'b001;
    else if (s < h + 2 * g) return 3'b011;
    else                    return 3'b111;
  endfunction

  function automatic logic legal(input logic [2:0] o);
    return (o == 3'b000) || (o == 3'b001) || (o == 3'b011) || (o == 3'b111);
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, push the model's expectation, pop and compare after the edge.
  task automatic step(input logic r, input logic e, input logic w, input logic s);
    exp_t x;
    rst = r; ext = e; wdt = w; sw = s;
    if (r) begin
      m_since = 0;
      m_cause = CAUSE_POR;
    end else if (e || w || s) begin
      m_since = 0;
      m_cause = e ? CAUSE_EXT : (w ? CAUSE_WDT : CAUSE_SW);
    end else if (m_since < 100000) begin
      m_since++;
    end
    x.out_a  = exp_out(m_since, H_A, G_A);
    x.busy_a = (x.out_a != 3'b111);
    x.out_b  = exp_out(m_since, H_B, G_B);
    x.busy_b = (x.out_b != 3'b111);
    x.cause  = m_cause;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("out_a",   out_a,            x.out_a);
    check("busy_a",  {2'b0, busy_a},   {2'b0, x.busy_a});
    check("cause_a", {1'b0, cause_a},  {1'b0, x.cause});
    check("out_b",   out_b,            x.out_b);
    check("busy_b",  {2'b0, busy_b},   {2'b0, x.busy_b});
    check("cause_b", {1'b0, cause_b},  {1'b0, x.cause});
    check("order_a", {2'b0, legal(out_a) && (busy_a == (out_a != 3'b111))}, 3'b001);
    check("order_b", {2'b0, legal(out_b) && (busy_b == (out_b != 3'b111))}, 3'b001);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int r;

    // Power-up: the fifth rst-high clock is edge 0.
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("por_reset_out",   out_a,           3'b000);
    check("por_reset_cause", {1'b0, cause_a}, 3'b000);
    for (int k = 1; k <= 26; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      case (k)
        15: check("por_e15", out_a, 3'b000);
        16: check("por_e16", out_a, 3'b001);
        19: check("por_e19", out_a, 3'b001);
        20: check("por_e20", out_a, 3'b011);
        23: check("por_e23_busy", {2'b0, busy_a}, 3'b001);
        24: begin
          check("por_e24", out_a, 3'b111);
          check("por_e24_busy", {2'b0, busy_a}, 3'b000);
          check("por_e24_cause", {1'b0, cause_a}, 3'b000);
        end
        default: ;
      endcase
    end
    $display("seq power-up done: out_a=%b cause=%b", out_a, cause_a);

    // Watchdog pulse while domain 0 is already released restarts everything.
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 44; k++) begin
      step(1'b0, 1'b0, k == 18, 1'b0);
      case (k)
        17: check("mid_e17", out_a, 3'b001);
        18: check("mid_e18", out_a, 3'b000);
        33: check("mid_e33", out_a, 3'b000);
        34: check("mid_e34", out_a, 3'b001);
        42: begin
          check("mid_e42", out_a, 3'b111);
          check("mid_e42_cause", {1'b0, cause_a}, {1'b0, CAUSE_WDT});
        end
        default: ;
      endcase
    end
    $display("seq mid-release restart done: out_a=%b cause=%b", out_a, cause_a);

    // Simultaneous wdt and sw: wdt wins; a lone sw later records sw.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("simul_cause", {1'b0, cause_a}, {1'b0, CAUSE_WDT});
    idle(30);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("sw_cause", {1'b0, cause_a}, {1'b0, CAUSE_SW});
    check("sw_b_e0", out_b, 3'b000);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      case (k)
        1: check("min_e1", out_b, 3'b001);
        2: check("min_e2", out_b, 3'b011);
        3: begin
          check("min_e3", out_b, 3'b111);
          check("min_e3_busy", {2'b0, busy_b}, 3'b000);
        end
        default: ;
      endcase
    end
    idle(30);
    $display("seq simultaneous/sw/min-params done: cause=%b out_b=%b", cause_a, out_b);

    // Button held 50 clocks; release timing counts from the last high sample.
    for (int k = 1; k <= 50; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 1) check("btn_first", out_a, 3'b000);
    end
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 15) check("btn_e15", out_a, 3'b000);
      if (k == 16) begin
        check("btn_e16", out_a, 3'b001);
        check("btn_cause", {1'b0, cause_a}, {1'b0, CAUSE_EXT});
      end
    end
    $display("seq button held done: out_a=%b cause=%b", out_a, cause_a);

    // rst asserted during REL1 clears outputs and cause at that edge.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_rel1_pre", out_a, 3'b011);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_rel1_out",   out_a,           3'b000);
    check("rst_rel1_cause", {1'b0, cause_a}, 3'b000);
    check("rst_rel1_busy",  {2'b0, busy_a},  3'b001);
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 16) check("rst_rel1_e16", out_a, 3'b001);
      if (k == 24) check("rst_rel1_e24", out_a, 3'b111);
    end
    $display("seq reset mid-operation done: out_a=%b cause=%b", out_a, cause_a);

    // Segment table: held pulses, mid-release requests, priority combinations.
    segs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 3,  "wdt held 3"};
    segs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 18, "idle into REL0"};
    segs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 2,  "sw held 2"};
    segs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 21, "idle into REL1"};
    segs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1,  "all causes"};
    segs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 30, "idle to RUN"};
    segs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 2,  "rst over ext"};
    segs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 30, "idle after rst"};
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < segs[i].cycles; c++)
        step(segs[i].r, segs[i].e, segs[i].w, segs[i].s);
      $display("seg %0d %s: out_a=%b out_b=%b cause=%b", i, segs[i].name, out_a, out_b, cause_a);
    end

    // Sparse random requests to exercise restarts at arbitrary points.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 999);
      step(r < 4, (r >= 4) && (r < 12), (r >= 12) && (r < 20), (r >= 20) && (r < 28));
    end
    $display("random run done: out_a=%b cause=%b", out_a, cause_a);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
